// File: rtl/adc_block_average.sv
// Multi-channel boxcar averager: sums 2^L valid samples per channel in parallel and
// emits the rounded mean of each channel with a one-cycle DONE strobe.
module adc_block_average #(
  parameter int ADC_WIDTH  = 12,
  parameter int NUM_CH     = 2,
  parameter int MAX_LOG2_N = 12,
  parameter int LOG2_W     = 4
) (
  input  logic                          ADC_CLK,
  input  logic                          RST,
  input  logic [NUM_CH*ADC_WIDTH-1:0]   ADC_DATA_IN,
  input  logic                          ADC_VALID,
  input  logic [LOG2_W-1:0]             LOG2_N,
  input  logic                          CONTINUOUS,
  input  logic                          START,
  input  logic                          STOP,
  output logic [NUM_CH*ADC_WIDTH-1:0]   AVE_OUT,
  output logic                          DONE,
  output logic                          BUSY,
  output logic [MAX_LOG2_N:0]           WIN_CNT
);

  localparam int ACC_W = ADC_WIDTH + MAX_LOG2_N;
  localparam int SUM_W = ACC_W + 1;
  localparam int CNT_W = MAX_LOG2_N + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                   state;
  logic [LOG2_W-1:0]        l_lat;
  logic                     cont_lat;
  logic signed [ACC_W-1:0]  acc     [NUM_CH];
  logic signed [ADC_WIDTH-1:0] smp  [NUM_CH];
  logic signed [SUM_W-1:0]  sum_nx  [NUM_CH];
  logic signed [ADC_WIDTH-1:0] mean_nx [NUM_CH];
  logic [LOG2_W-1:0]        l_clamp;
  logic [CNT_W-1:0]         last_cnt;
  logic                     last_smp;

  // Round half toward +inf, then arithmetic shift; the mean of in-range samples
  // always fits ADC_WIDTH, so the truncation below never loses information.
  function automatic logic signed [ADC_WIDTH-1:0] round_mean(
    input logic signed [SUM_W-1:0] sum,
    input logic [LOG2_W-1:0]       l
  );
    logic signed [SUM_W-1:0] bias;
    logic signed [SUM_W-1:0] t;
    logic signed [SUM_W-1:0] q;
    bias = (l == '0) ? '0 : (SUM_W'(1) << (l - LOG2_W'(1)));
    t    = sum + bias;
    q    = t >>> l;
    return q[ADC_WIDTH-1:0];
  endfunction

  always_comb begin
    l_clamp = (int'(LOG2_N) > MAX_LOG2_N) ? LOG2_W'(MAX_LOG2_N) : LOG2_N;
    last_cnt = (CNT_W'(1) << l_lat) - CNT_W'(1);
    last_smp = ADC_VALID && (WIN_CNT == last_cnt);
  end

  // Widen accumulator by one bit so the final add plus rounding bias cannot wrap.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      smp[k]     = ADC_DATA_IN[k*ADC_WIDTH +: ADC_WIDTH];
      sum_nx[k]  = {acc[k][ACC_W-1], acc[k]}
                 + {{(SUM_W-ADC_WIDTH){smp[k][ADC_WIDTH-1]}}, smp[k]};
      mean_nx[k] = round_mean(sum_nx[k], l_lat);
    end
  end

  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      state    <= IDLE;
      l_lat    <= '0;
      cont_lat <= 1'b0;
      DONE     <= 1'b0;
      BUSY     <= 1'b0;
      WIN_CNT  <= '0;
      AVE_OUT  <= '0;
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          WIN_CNT <= '0;
          for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
          if (START && !STOP) begin
            state    <= ACCUM;
            BUSY     <= 1'b1;
            l_lat    <= l_clamp;
            cont_lat <= CONTINUOUS;
          end
        end
        ACCUM: begin
          // STOP wins over a coincident last sample: the window is simply dropped.
          if (STOP) begin
            state   <= IDLE;
            BUSY    <= 1'b0;
            WIN_CNT <= '0;
            for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
          end else if (last_smp) begin
            DONE    <= 1'b1;
            WIN_CNT <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
              acc[k] <= '0;
              AVE_OUT[k*ADC_WIDTH +: ADC_WIDTH] <= mean_nx[k];
            end
            if (!cont_lat) begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end
          end else if (ADC_VALID) begin
            WIN_CNT <= WIN_CNT + CNT_W'(1);
            for (int k = 0; k < NUM_CH; k++) acc[k] <= sum_nx[k][ACC_W-1:0];
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_block_average.sv
// Directed plus randomized bench for adc_block_average against a queue-based
// window model that computes each mean by floor division.
module tb_adc_block_average;
  localparam int AW   = 12;
  localparam int NCH  = 2;
  localparam int MAXL = 12;
  localparam int LW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stop, valid, cont;
  logic [LW-1:0] log2n;
  int d0, d1;
  logic [NCH*AW-1:0] adc_data, ave_out;
  logic done, busy;
  logic [MAXL:0] win_cnt;

  assign adc_data = {d1[AW-1:0], d0[AW-1:0]};

  adc_block_average #(.ADC_WIDTH(AW), .NUM_CH(NCH), .MAX_LOG2_N(MAXL), .LOG2_W(LW)) dut (
    .ADC_CLK(clk), .RST(rst), .ADC_DATA_IN(adc_data), .ADC_VALID(valid),
    .LOG2_N(log2n), .CONTINUOUS(cont), .START(start), .STOP(stop),
    .AVE_OUT(ave_out), .DONE(done), .BUSY(busy), .WIN_CNT(win_cnt)
  );

  int checks = 0;
  int errors = 0;

  bit m_busy, m_cont, exp_done;
  int m_l;
  int q0[$];
  int q1[$];
  int m_ave0 = 0;
  int m_ave1 = 0;

  function automatic int mean_of(input int q[$], input int l);
    longint sum, d, num, quo;
    sum = 0;
    foreach (q[i]) sum += q[i];
    d   = longint'(1) << l;
    num = sum + ((l > 0) ? d / 2 : 0);
    quo = num / d;
    if ((num % d) != 0 && num < 0) quo = quo - 1;
    return int'(quo);
  endfunction

  task automatic model_edge();
    exp_done = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_cont = 1'b0; m_l = 0;
      q0.delete(); q1.delete();
      m_ave0 = 0; m_ave1 = 0;
    end else if (!m_busy) begin
      if (start && !stop) begin
        m_busy = 1'b1;
        m_l    = (int'(log2n) > MAXL) ? MAXL : int'(log2n);
        m_cont = cont;
      end
    end else if (stop) begin
      m_busy = 1'b0;
      q0.delete(); q1.delete();
    end else if (valid) begin
      q0.push_back(d0);
      q1.push_back(d1);
      if (q0.size() == (1 << m_l)) begin
        m_ave0 = mean_of(q0, m_l);
        m_ave1 = mean_of(q1, m_l);
        exp_done = 1'b1;
        q0.delete(); q1.delete();
        if (!m_cont) m_busy = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [NCH*AW-1:0] e_ave;
    model_edge();
    @(posedge clk);
    #1;
    e_ave = {m_ave1[AW-1:0], m_ave0[AW-1:0]};
    chk("done", 32'(done), 32'(exp_done));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("win_cnt", 32'(win_cnt), q0.size());
    chk("ave_out", 32'(ave_out), 32'(e_ave));
  endtask

  task automatic arm(input int l, input bit c);
    start = 1'b1; log2n = LW'(l); cont = c; valid = 1'b0;
    step();
    start = 1'b0;
  endtask

  int pk;
  logic [NCH*AW-1:0] saved;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; valid = 1'b0; cont = 1'b0;
    log2n = '0; d0 = 0; d1 = 0;
    step(); step();
    chk("reset_ave", 32'(ave_out), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    step();

    // Single-shot ramp, L=3
    arm(3, 1'b0);
    valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d0 = i; d1 = -5;
      step();
      if (i == 6) chk("ramp_no_early_done", 32'(done), 32'h0);
    end
    chk("ramp_done", 32'(done), 32'h1);
    chk("ramp_busy_fall", 32'(busy), 32'h0);
    chk("ramp_ave", 32'(ave_out), 32'({12'hFFB, 12'h004}));
    valid = 1'b0;
    step();
    chk("ramp_done_oneshot", 32'(done), 32'h0);

    // Reset mid-window, L=4, after 7 samples
    arm(4, 1'b0);
    valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      d0 = 100 + i; d1 = -100 - i;
      step();
    end
    rst = 1'b1; valid = 1'b0;
    step();
    chk("rstmid_ave", 32'(ave_out), 32'h0);
    chk("rstmid_cnt", 32'(win_cnt), 32'h0);
    chk("rstmid_done", 32'(done), 32'h0);
    rst = 1'b0;
    step();

    // Continuous gapless, L=2
    arm(2, 1'b1);
    valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d0 = i / 4 + 1; d1 = -(i / 4);
      step();
      if (i == 3) chk("cont_w1", 32'(ave_out), 32'({12'h000, 12'h001}));
      if (i == 7) chk("cont_w2", 32'(ave_out), 32'({12'hFFF, 12'h002}));
      chk("cont_done_period", 32'(done), 32'((i % 4) == 3));
    end
    valid = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0;
    step();

    // Extremes with 50% valid duty, L=10
    d0 = 2047; d1 = -2048;
    arm(10, 1'b0);
    pk = 0;
    for (int i = 0; i < 2048; i++) begin
      valid = (i % 2) == 1;
      step();
      if (int'(win_cnt) > pk) pk = int'(win_cnt);
    end
    chk("ext_done", 32'(done), 32'h1);
    chk("ext_ave", 32'(ave_out), 32'({12'h800, 12'h7FF}));
    chk("ext_peak", pk, 1023);
    valid = 1'b0;
    step();

    // STOP coincident with last sample
    saved = ave_out;
    arm(2, 1'b0);
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d0 = int'($urandom_range(0, 4095)) - 2048; d1 = 7;
      step();
    end
    stop = 1'b1;
    step();
    chk("stop_last_done", 32'(done), 32'h0);
    chk("stop_last_ave", 32'(ave_out), 32'(saved));
    stop = 1'b0; valid = 1'b0;
    step();

    // START during ACCUM with new LOG2_N is ignored
    arm(1, 1'b0);
    valid = 1'b1; d0 = 10; d1 = 20;
    step();
    start = 1'b1; log2n = 4'd5; d0 = 11; d1 = 21;
    step();
    chk("start_ignored_done", 32'(done), 32'h1);
    chk("start_ignored_ave", 32'(ave_out), 32'({12'd21, 12'd11}));
    start = 1'b0; valid = 1'b0;
    step();

    // START with STOP in IDLE stays IDLE
    start = 1'b1; stop = 1'b1;
    step();
    chk("start_stop_idle", 32'(busy), 32'h0);
    start = 1'b0; stop = 1'b0;
    step();

    // L=0: every valid sample is its own window
    arm(0, 1'b1);
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d0 = int'($urandom_range(0, 4095)) - 2048;
      d1 = int'($urandom_range(0, 4095)) - 2048;
      step();
      chk("l0_ave", 32'(ave_out), 32'({d1[AW-1:0], d0[AW-1:0]}));
    end
    valid = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0;

    // LOG2_N=15 clamps to 4096-sample window
    arm(15, 1'b0);
    valid = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      d0 = int'($urandom_range(0, 4095)) - 2048;
      d1 = int'($urandom_range(0, 4095)) - 2048;
      step();
      if (i == 4094) chk("clamp_not_yet", 32'(done), 32'h0);
    end
    chk("clamp_done", 32'(done), 32'h1);
    valid = 1'b0;
    step();

    // Randomized control and data
    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      valid = ($urandom_range(0, 3) != 0);
      cont  = $urandom_range(0, 1) == 1;
      log2n = LW'($urandom_range(0, 5));
      d0 = int'($urandom_range(0, 4095)) - 2048;
      d1 = int'($urandom_range(0, 4095)) - 2048;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_block_average.md
# adc_block_average

Parametrised multi-channel boxcar averager for the SPGD ADC front end, the successor to the single-channel fixed-window averager inside the ADC→DAC loop. It accumulates 2^LOG2_N valid samples per channel in parallel, outputs the rounded mean of each channel with a one-cycle DONE strobe, and runs either single-shot (armed by START) or continuously with no dropped samples between windows. It sits between the ADC capture register and the loop filter / GPIO readback, in the ADC_CLK domain.

## Interface
- ADC_WIDTH, 12: bits per channel sample, two's complement signed.
- NUM_CH, 2: number of channels averaged in lockstep.
- MAX_LOG2_N, 12: largest supported log2 window length; sets accumulator width ADC_WIDTH+MAX_LOG2_N.
- LOG2_W, 4: width of the LOG2_N port.

- ADC_CLK  in  1  sole clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- ADC_DATA_IN  in  NUM_CH*ADC_WIDTH  channel k at bits [k*ADC_WIDTH +: ADC_WIDTH].
- ADC_VALID  in  1  sample qualifier; a sample counts only when high.
- LOG2_N  in  LOG2_W  window length 2^LOG2_N; latched at START.
- CONTINUOUS  in  1  1 = restart automatically after each window; latched at START.
- START  in  1  arm/begin averaging (level sampled; acted on only in IDLE).
- STOP  in  1  abort current window, return to IDLE, no DONE.
- AVE_OUT  out  NUM_CH*ADC_WIDTH  registered rounded means, same packing as input.
- DONE  out  1  one-cycle strobe; AVE_OUT updated in the same cycle.
- BUSY  out  1  high in ACCUM.
- WIN_CNT  out  MAX_LOG2_N+1  valid samples accumulated in the current window.

## Operation
- States: IDLE, ACCUM.
- IDLE: accumulators and WIN_CNT held at 0. START=1 → ACCUM next cycle; latch L = min(LOG2_N, MAX_LOG2_N) and CONTINUOUS.
- ACCUM: each cycle with ADC_VALID=1, ACC[k] += sign-extended sample k and WIN_CNT += 1.
- Last sample (ADC_VALID=1 and WIN_CNT = 2^L−1): AVE_OUT[k] <= (ACC[k]+sample[k]+R) >>> L with R = 2^(L−1) for L>0, R = 0 for L=0 (round half toward +inf, arithmetic shift); ACC and WIN_CNT cleared; DONE=1 next cycle.
  - CONTINUOUS=1: remain in ACCUM; next window starts on the following cycle with no gap.
  - CONTINUOUS=0: go to IDLE.
- Result always fits ADC_WIDTH (mean of in-range values rounded lies in range); no saturation logic.
- STOP=1 in ACCUM: → IDLE, ACC/WIN_CNT cleared, AVE_OUT unchanged, no DONE. STOP takes priority over a coincident last sample. STOP in IDLE: no effect; START and STOP together in IDLE: stay IDLE.
- START while in ACCUM: ignored; LOG2_N/CONTINUOUS changes in ACCUM have no effect until the next START from IDLE.
- L=0: every valid sample produces DONE with AVE_OUT = sample.

## Timing
- Reset (RST=1 at an edge): state IDLE, AVE_OUT=0, DONE=0, BUSY=0, WIN_CNT=0, accumulators 0, latched L=0, latched CONTINUOUS=0. Applies mid-window; the partial window is discarded.
- START seen at edge t → BUSY=1 from t+1; first countable sample is the one presented in the cycle after t.
- Last valid sample at edge t → DONE=1 and new AVE_OUT during cycle t+1 only; single-shot BUSY=0 from t+1.
- Minimum window period, ADC_VALID continuously high: 2^L cycles; DONE period in continuous mode exactly 2^L cycles.
- ADC_VALID gaps stretch the window; they do not reset it.
- Latency from last sample to output: 1 cycle; no combinational path from inputs to outputs.

## Test plan
- Reset mid-window: NUM_CH=2, L=4, assert RST after 7 samples → all outputs 0, IDLE next cycle; no DONE.
- Single-shot ramp: L=3, CONTINUOUS=0, ch0 samples 0..7, ch1 constant −5 → one DONE 1 cycle after 8th sample, AVE_OUT ch0=4 (3.5 rounds up), ch1=−5; BUSY falls same cycle as DONE.
- Continuous, gapless: L=2, ADC_VALID=1 always, ch0 = 1,1,1,1,2,2,2,2,… → DONE every 4 cycles, AVE_OUT 1 then 2; no sample lost across window boundary.
- Valid gaps and extremes: L=10, ADC_VALID 50 % duty, all ch0=2047, ch1=−2048 → DONE after 1024 valid samples (~2048 cycles), AVE_OUT 2047 / −2048, WIN_CNT peaks at 1023.
- STOP/START priority: STOP coincident with last sample → no DONE, AVE_OUT unchanged; START during ACCUM with new LOG2_N → ignored, window length unchanged.
- L=0 and clamp: LOG2_N=0 → DONE per valid sample with AVE_OUT=sample; LOG2_N=15 with MAX_LOG2_N=12 → window 4096 samples.
